// File: rtl/he_null_mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : he_null_mmio_pkg
// Description : Shared constants and types for the HE-NULL MMIO CSR endpoint.
//               It holds the CSR qword offsets, the response FIFO depth and
//               the response entry type carried through the FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package he_null_mmio_pkg;

    // CSR qword offsets within the 4 KB window
    localparam logic [11:0] c_OFF_DFH     = 12'h000;
    localparam logic [11:0] c_OFF_GUID_L  = 12'h008;
    localparam logic [11:0] c_OFF_GUID_H  = 12'h010;
    localparam logic [11:0] c_OFF_SCRATCH = 12'h018;
    localparam logic [11:0] c_OFF_STATUS  = 12'h020;

    // Response FIFO depth and the matching "full" count value
    localparam int          c_FIFO_DEPTH    = 2;
    localparam logic [1:0]  c_FIFO_CNT_FULL = 2'(c_FIFO_DEPTH);

    // Tag field is sized for the widest supported TAG_W; narrower tags are
    // zero-extended on push and truncated on pop.
    localparam int c_RSP_TAG_MAX_W = 16;

    typedef struct packed {
        logic [c_RSP_TAG_MAX_W-1:0] tag;
        logic [63:0]                data;
    } rsp_entry_t;

    // Place the selected dword of a qword in the low half, upper half zero.
    function automatic logic [63:0] dword_lane(input logic [63:0] qword,
                                               input logic        hi);
        return hi ? {32'h0, qword[63:32]} : {32'h0, qword[31:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/he_null_mmio_csr_if.sv
`default_nettype none
// ============================================================================
// Module      : he_null_mmio_csr_if
// Description : Host MMIO request / read-completion bundle for the HE-NULL
//               CSR endpoint.
//               master : host side, drives requests, consumes completions.
//               slave  : endpoint side, accepts requests, returns completions
//                        and the error pulse.
//               Request : req_valid/req_ready, req_write, req_len64, req_addr,
//                         req_tag, req_wdata, req_pf, req_vf, req_vfa
//               Response: rsp_valid/rsp_ready, rsp_tag, rsp_data
//               Status  : err_pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface he_null_mmio_csr_if #(
    parameter int ADDR_W = 20,
    parameter int TAG_W  = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_len64;
    logic [ADDR_W-1:0] req_addr;
    logic [TAG_W-1:0]  req_tag;
    logic [63:0]       req_wdata;
    logic [2:0]        req_pf;
    logic [10:0]       req_vf;
    logic              req_vfa;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [TAG_W-1:0]  rsp_tag;
    logic [63:0]       rsp_data;
    logic              err_pulse;

    modport master (
        output req_valid, req_write, req_len64, req_addr, req_tag, req_wdata,
               req_pf, req_vf, req_vfa, rsp_ready,
        input  req_ready, rsp_valid, rsp_tag, rsp_data, err_pulse
    );

    modport slave (
        input  req_valid, req_write, req_len64, req_addr, req_tag, req_wdata,
               req_pf, req_vf, req_vfa, rsp_ready,
        output req_ready, rsp_valid, rsp_tag, rsp_data, err_pulse
    );
endinterface
`default_nettype wire

// File: rtl/he_null_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : he_null_rsp_fifo
// Description : 2-entry first-word-fall-through response FIFO. The head
//               entry is held in a register and drives the outputs directly,
//               so out_data is stable while out_valid is high and not popped.
//               Ports: clk, rst_n (async, active-low), push/push_data,
//               pop, out_valid/out_data (head), count (occupancy 0..2).
// Revision    : 1.0 - initial release
// ============================================================================
module he_null_rsp_fifo
    import he_null_mmio_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  rsp_entry_t push_data,
    input  logic       pop,
    output logic       out_valid,
    output rsp_entry_t out_data,
    output logic [1:0] count
);

    rsp_entry_t r_head;
    rsp_entry_t r_tail;
    logic [1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    // A pop on an empty FIFO is ignored; a push on a full FIFO is only
    // honoured when the head leaves in the same cycle.
    assign w_do_pop  = pop && (r_count != 2'd0);
    assign w_do_push = push && ((r_count != c_FIFO_CNT_FULL) || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({w_do_push, w_do_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= push_data;
                    end else begin
                        r_tail <= push_data;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the older entry moves to the head
                    // so ordering is kept.
                    if (r_count == 2'd1) begin
                        r_head <= push_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_head;
    assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/he_null_mmio_csr.sv
`default_nettype none
// ============================================================================
// Module      : he_null_mmio_csr
// Description : HE-NULL MMIO CSR endpoint. Filters routed host MMIO requests
//               against its PF/VF identity, decodes the CSR window
//               (DFH, GUID_L, GUID_H, SCRATCHPAD, STATUS) and returns read
//               completions through a 2-entry FWFT response FIFO.
//               Ports: clk, rst_n (async, active-low), bus (slave modport of
//               he_null_mmio_csr_if: request, response and err_pulse).
//               TAG_W must not exceed 16 and ADDR_W must exceed 12.
// Revision    : 1.0 - initial release
// ============================================================================
module he_null_mmio_csr
    import he_null_mmio_pkg::*;
#(
    parameter int          ADDR_W       = 20,
    parameter int          TAG_W        = 10,
    parameter int          PF_NUM       = 0,
    parameter int          VF_NUM       = 0,
    parameter int          VF_ACTIVE    = 0,
    parameter logic [63:0] DFH_VALUE    = 64'h1000_0000_1000_0001,
    parameter logic [63:0] GUID_L_VALUE = 64'hA5A5_0000_0000_0001,
    parameter logic [63:0] GUID_H_VALUE = 64'h5A5A_0000_0000_0002
)(
    input  logic              clk,
    input  logic              rst_n,
    he_null_mmio_csr_if.slave bus
);

    localparam logic [2:0]  c_PF  = 3'(PF_NUM);
    localparam logic [10:0] c_VF  = 11'(VF_NUM);
    localparam logic        c_VFA = 1'(VF_ACTIVE);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic        r_ready_en;
    logic        r_err_pulse;
    logic [63:0] r_scratch;
    logic [15:0] r_err_cnt;
    logic [15:0] r_rd_cnt;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic        w_req_ready;
    logic        w_accept;
    logic        w_fn_match;
    logic        w_misalign;
    logic        w_err;
    logic        w_in_window;
    logic [11:0] w_qoff;
    logic [63:0] w_qword;
    logic [63:0] w_rd_data;
    logic        w_wr_ok;
    logic        w_rd_acc;
    logic [1:0]  w_fifo_count;
    logic        w_fifo_valid;
    rsp_entry_t  w_fifo_out;
    rsp_entry_t  w_push_entry;

    assign w_accept = bus.req_valid && w_req_ready;

    // req_vf only participates when this block is a VF
    assign w_fn_match = (bus.req_pf == c_PF) &&
                        (bus.req_vfa == c_VFA) &&
                        (!c_VFA || (bus.req_vf == c_VF));

    assign w_misalign = (bus.req_addr[1:0] != 2'b00) ||
                        (bus.req_len64 && bus.req_addr[2]);

    assign w_err = !w_fn_match || w_misalign;

    assign w_in_window = (bus.req_addr[ADDR_W-1:12] == '0);
    assign w_qoff      = {bus.req_addr[11:3], 3'b000};

    // Qword read mux; holes and out-of-window addresses read as zero.
    always_comb begin
        w_qword = 64'h0;
        if (w_in_window) begin
            case (w_qoff)
                c_OFF_DFH:     w_qword = DFH_VALUE;
                c_OFF_GUID_L:  w_qword = GUID_L_VALUE;
                c_OFF_GUID_H:  w_qword = GUID_H_VALUE;
                c_OFF_SCRATCH: w_qword = r_scratch;
                c_OFF_STATUS:  w_qword = {32'h0, r_rd_cnt, r_err_cnt};
                default:       w_qword = 64'h0;
            endcase
        end
    end

    always_comb begin
        w_rd_data = 64'h0;
        if (w_err) begin
            w_rd_data = '1;
        end else if (bus.req_len64) begin
            w_rd_data = w_qword;
        end else begin
            w_rd_data = dword_lane(w_qword, bus.req_addr[2]);
        end
    end

    assign w_rd_acc = w_accept && !bus.req_write;
    assign w_wr_ok  = w_accept && bus.req_write && !w_err && w_in_window;

    assign w_push_entry.tag  = c_RSP_TAG_MAX_W'(bus.req_tag);
    assign w_push_entry.data = w_rd_data;

    // ------------------------------------------------------------------
    // Registers and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready_en  <= 1'b0;
            r_err_pulse <= 1'b0;
            r_scratch   <= 64'h0;
            r_err_cnt   <= 16'h0;
            r_rd_cnt    <= 16'h0;
        end else begin
            // Holds req_ready low until the first edge after reset release
            r_ready_en  <= 1'b1;
            r_err_pulse <= w_accept && w_err;

            if (w_wr_ok && (w_qoff == c_OFF_SCRATCH)) begin
                if (bus.req_len64) begin
                    r_scratch <= bus.req_wdata;
                end else if (bus.req_addr[2]) begin
                    r_scratch[63:32] <= bus.req_wdata[31:0];
                end else begin
                    r_scratch[31:0] <= bus.req_wdata[31:0];
                end
            end

            // An erroring request is never a valid STATUS write, so the
            // increment and the clear cannot collide.
            if (w_accept && w_err) begin
                if (r_err_cnt != 16'hFFFF) begin
                    r_err_cnt <= r_err_cnt + 16'h1;
                end
            end else if (w_wr_ok && (w_qoff == c_OFF_STATUS)) begin
                r_err_cnt <= 16'h0;
            end

            // Counts matched reads even when misaligned
            if (w_rd_acc && w_fn_match) begin
                r_rd_cnt <= r_rd_cnt + 16'h1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response path
    // ------------------------------------------------------------------
    he_null_rsp_fifo u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_rd_acc),
        .push_data (w_push_entry),
        .pop       (bus.rsp_ready),
        .out_valid (w_fifo_valid),
        .out_data  (w_fifo_out),
        .count     (w_fifo_count)
    );

    assign w_req_ready   = r_ready_en && (w_fifo_count != c_FIFO_CNT_FULL);
    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = w_fifo_valid;
    assign bus.rsp_tag   = w_fifo_out.tag[TAG_W-1:0];
    assign bus.rsp_data  = w_fifo_out.data;
    assign bus.err_pulse = r_err_pulse;

endmodule
`default_nettype wire

// File: tb/tb_he_null_mmio_csr.sv
`default_nettype none
// ============================================================================
// Module      : tb_he_null_mmio_csr
// Description : Self-checking bench for he_null_mmio_csr. A behavioural CSR
//               model tracks expected completions, counters and err_pulse;
//               directed scenarios add literal checks on captured responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_he_null_mmio_csr;

    localparam logic [63:0] c_DFH  = 64'h1000_0000_1000_0001;
    localparam logic [63:0] c_GL   = 64'hA5A5_0000_0000_0001;
    localparam logic [63:0] c_GH   = 64'h5A5A_0000_0000_0002;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    he_null_mmio_csr_if #(.ADDR_W(20), .TAG_W(10)) bus ();

    he_null_mmio_csr #(
        .ADDR_W(20), .TAG_W(10), .PF_NUM(0), .VF_NUM(0), .VF_ACTIVE(0),
        .DFH_VALUE(c_DFH), .GUID_L_VALUE(c_GL), .GUID_H_VALUE(c_GH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { logic [9:0] tag; logic [63:0] data; } exp_t;
    exp_t        m_q[$];
    logic [63:0] m_scratch = 0;
    logic [15:0] m_err = 0;
    logic [15:0] m_rd = 0;
    bit          m_err_now = 0;
    bit          prev_hi = 0;
    int          err_seen = 0;
    logic [63:0] log_data[$];
    logic [9:0]  log_tag[$];

    function automatic logic [63:0] m_read(input logic [19:0] a, input bit l64);
        logic [63:0] q;
        q = 64'h0;
        if (a[19:12] == 8'h0) begin
            case (a[11:3])
                9'd0: q = c_DFH;
                9'd1: q = c_GL;
                9'd2: q = c_GH;
                9'd3: q = m_scratch;
                9'd4: q = {32'h0, m_rd, m_err};
                default: q = 64'h0;
            endcase
        end
        if (l64) return q;
        return a[2] ? {32'h0, q[63:32]} : {32'h0, q[31:0]};
    endfunction

    task automatic m_accept();
        bit fn, er;
        exp_t e;
        fn = (bus.req_pf == 3'd0) && (bus.req_vfa == 1'b0);
        er = !fn || (bus.req_addr[1:0] != 2'b00) || (bus.req_len64 && bus.req_addr[2]);
        if (!bus.req_write) begin
            e.tag  = bus.req_tag;
            e.data = er ? 64'hFFFF_FFFF_FFFF_FFFF : m_read(bus.req_addr, bus.req_len64);
            m_q.push_back(e);
            if (fn) m_rd++;
        end else if (!er && bus.req_addr[19:12] == 8'h0) begin
            if (bus.req_addr[11:3] == 9'd3) begin
                if (bus.req_len64) m_scratch = bus.req_wdata;
                else if (bus.req_addr[2]) m_scratch[63:32] = bus.req_wdata[31:0];
                else m_scratch[31:0] = bus.req_wdata[31:0];
            end else if (bus.req_addr[11:3] == 9'd4) begin
                m_err = 16'h0;
            end
        end
        if (er) begin
            m_err_now = 1;
            if (m_err != 16'hFFFF) m_err++;
        end
    endtask

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_req_ready", {63'h0, bus.req_ready}, 64'h0);
                chk("rst_rsp_valid", {63'h0, bus.rsp_valid}, 64'h0);
                chk("rst_rsp_tag", {54'h0, bus.rsp_tag}, 64'h0);
                chk("rst_rsp_data", bus.rsp_data, 64'h0);
                chk("rst_err_pulse", {63'h0, bus.err_pulse}, 64'h0);
                m_q.delete();
                m_scratch = 0; m_err = 0; m_rd = 0; m_err_now = 0; prev_hi = 0;
            end else begin
                chk("req_ready", {63'h0, bus.req_ready}, {63'h0, prev_hi && (m_q.size() != 2)});
                chk("rsp_valid", {63'h0, bus.rsp_valid}, {63'h0, m_q.size() != 0});
                if (m_q.size() != 0) begin
                    chk("rsp_tag", {54'h0, bus.rsp_tag}, {54'h0, m_q[0].tag});
                    chk("rsp_data", bus.rsp_data, m_q[0].data);
                end
                chk("err_pulse", {63'h0, bus.err_pulse}, {63'h0, m_err_now});
                if (bus.err_pulse) err_seen++;
                m_err_now = 0;
                if (bus.rsp_valid && bus.rsp_ready) begin
                    log_data.push_back(bus.rsp_data);
                    log_tag.push_back(bus.rsp_tag);
                    if (m_q.size() != 0) void'(m_q.pop_front());
                end
                if (bus.req_valid && bus.req_ready) m_accept();
                prev_hi = 1;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(input bit wr, input bit l64, input logic [19:0] a,
                        input logic [9:0] tag, input logic [63:0] wd, input logic [2:0] pf);
        bit ok;
        ok = 0;
        bus.req_write = wr; bus.req_len64 = l64; bus.req_addr = a;
        bus.req_tag = tag; bus.req_wdata = wd; bus.req_pf = pf;
        bus.req_valid = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = bus.req_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL send_timeout: addr %h never accepted", a);
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (m_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (m_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: %0d responses outstanding", m_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    int base;
    int ebase;

    initial begin
        bus.req_valid = 0; bus.req_write = 0; bus.req_len64 = 0; bus.req_addr = '0;
        bus.req_tag = '0; bus.req_wdata = '0; bus.req_pf = '0; bus.req_vf = '0;
        bus.req_vfa = 0; bus.rsp_ready = 1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // ID registers
        base = log_data.size();
        send(0, 1, 20'h00000, 10'd5, 64'h0, 3'd0);
        send(0, 1, 20'h00008, 10'd5, 64'h0, 3'd0);
        send(0, 1, 20'h00010, 10'd5, 64'h0, 3'd0);
        drain();
        chk("id_tag", {54'h0, log_tag[base]}, 64'd5);
        chk("id_dfh", log_data[base], 64'h1000_0000_1000_0001);
        chk("id_guid_l", log_data[base+1], 64'hA5A5_0000_0000_0001);
        chk("id_guid_h", log_data[base+2], 64'h5A5A_0000_0000_0002);

        // Scratchpad write then next-cycle 32-bit reads
        base = log_data.size();
        send(1, 1, 20'h00018, 10'd0, 64'hDEAD_BEEF_0123_4567, 3'd0);
        send(0, 0, 20'h0001C, 10'd6, 64'h0, 3'd0);
        send(0, 0, 20'h00018, 10'd6, 64'h0, 3'd0);
        drain();
        chk("scr_hi32", log_data[base], 64'h0000_0000_DEAD_BEEF);
        chk("scr_lo32", log_data[base+1], 64'h0000_0000_0123_4567);

        // Function mismatch, STATUS, STATUS clear, out-of-window
        base = log_data.size();
        ebase = err_seen;
        send(0, 1, 20'h00000, 10'd7, 64'h0, 3'd1);
        send(0, 1, 20'h00020, 10'd8, 64'h0, 3'd0);
        send(1, 0, 20'h00020, 10'd0, 64'h0, 3'd0);
        send(0, 1, 20'h00020, 10'd9, 64'h0, 3'd0);
        send(0, 1, 20'h01000, 10'd20, 64'h0, 3'd0);
        drain();
        chk("fn_err_data", log_data[base], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("fn_err_pulses", err_seen - ebase, 64'd1);
        chk("status_err1", log_data[base+1], 64'h0000_0000_0005_0001);
        chk("status_clr", log_data[base+2], 64'h0000_0000_0006_0000);
        chk("out_window", log_data[base+3], 64'h0);

        // Backpressure: 3 reads with rsp_ready low
        base = log_data.size();
        bus.rsp_ready = 0;
        fork
            begin
                send(0, 1, 20'h00000, 10'd10, 64'h0, 3'd0);
                send(0, 1, 20'h00008, 10'd11, 64'h0, 3'd0);
                send(0, 1, 20'h00018, 10'd12, 64'h0, 3'd0);
            end
            begin
                repeat (8) @(negedge clk);
                chk("bp_req_ready", {63'h0, bus.req_ready}, 64'h0);
                chk("bp_rsp_valid", {63'h0, bus.rsp_valid}, 64'h1);
                chk("bp_head_tag", {54'h0, bus.rsp_tag}, 64'd10);
                @(posedge clk);
                #1 bus.rsp_ready = 1;
            end
        join
        drain();
        chk("bp_tag0", {54'h0, log_tag[base]}, 64'd10);
        chk("bp_tag1", {54'h0, log_tag[base+1]}, 64'd11);
        chk("bp_tag2", {54'h0, log_tag[base+2]}, 64'd12);
        chk("bp_data2", log_data[base+2], 64'hDEAD_BEEF_0123_4567);

        // Misaligned 64-bit write is dropped and counted
        base = log_data.size();
        send(1, 1, 20'h0001C, 10'd0, 64'h1111_2222_3333_4444, 3'd0);
        send(0, 1, 20'h00020, 10'd16, 64'h0, 3'd0);
        send(0, 1, 20'h00018, 10'd17, 64'h0, 3'd0);
        send(0, 0, 20'h00019, 10'd18, 64'h0, 3'd0);
        drain();
        chk("unal_status", log_data[base], 64'h0000_0000_000B_0001);
        chk("unal_scratch", log_data[base+1], 64'hDEAD_BEEF_0123_4567);
        chk("unal_rd_err", log_data[base+2], 64'hFFFF_FFFF_FFFF_FFFF);

        // Reset with two completions pending
        bus.rsp_ready = 0;
        send(0, 1, 20'h00000, 10'd13, 64'h0, 3'd0);
        send(0, 1, 20'h00008, 10'd14, 64'h0, 3'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rsp_valid", {63'h0, bus.rsp_valid}, 64'h0);
        chk("rst_mid_req_ready", {63'h0, bus.req_ready}, 64'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus.rsp_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        base = log_data.size();
        send(0, 1, 20'h00018, 10'd15, 64'h0, 3'd0);
        send(0, 1, 20'h00020, 10'd19, 64'h0, 3'd0);
        drain();
        chk("rst_scratch", log_data[base], 64'h0);
        chk("rst_status", log_data[base+1], 64'h0000_0000_0001_0000);
        chk("rst_log_len", log_data.size() - base, 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
